// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver:
// register map, CTRL bit positions, reset values and the hex-to-segment table.
package seg7_pkg;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_DIGITS   = 3'd1,
    REG_DP       = 3'd2,
    REG_SCAN_DIV = 3'd3,
    REG_BRIGHT   = 3'd4,
    REG_RSVD5    = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_sel_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;
  localparam int CTRL_OE  = 2;

  localparam int unsigned SCAN_DIV_RST = 999;
  localparam logic [3:0]  BRIGHT_RST   = 4'hF;

  // Entry n holds {g,f,e,d,c,b,a} for hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Merge a bus write into an old register value, one byte lane per sel bit
  function automatic logic [31:0] wb_merge(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  sel
  );
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment pattern lookup.
// Output bit order is {g,f,e,d,c,b,a}, active high.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup from the shared package
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Wishbone-programmable time-multiplexed 7-segment display driver.
// Optional brightness PWM is built when SEG7_BRIGHTNESS_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_DIV_W = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [8+NUM_DIGITS-1:0] io_oeb
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int OW = 8 + NUM_DIGITS;

  logic [2:0]            ctrl_q, ctrl_d;
  logic [DW-1:0]         digits_q, digits_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [SCAN_DIV_W-1:0] scan_div_q, scan_div_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [SCAN_DIV_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [OW-1:0]         oeb_q, oeb_d;

`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0]            bright_q, bright_d;
  logic [3:0]            pwm_q, pwm_d;
`endif

  reg_sel_e    rsel;
  logic        hit;
  logic        req;
  logic        wr;
  logic        div_wr;
  logic [31:0] wr_val;
  logic [31:0] rd_data;
  logic        en;
  logic        inv;
  logic        pwm_on;
  logic [3:0]  nib;
  logic [6:0]  hex_seg;
  logic        unused_ok;

  assign rsel = reg_sel_e'(wbs_adr_i[4:2]);
  assign hit  = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign req  = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr   = req & wbs_we_i;
  assign en   = ctrl_q[CTRL_EN];
  assign inv  = ctrl_q[CTRL_INV];

  // Register file update; a write lands on the edge that raises ack
  always_comb begin
    ctrl_d     = ctrl_q;
    digits_d   = digits_q;
    dp_d       = dp_q;
    scan_div_d = scan_div_q;
    div_wr     = 1'b0;
    wr_val     = '0;
`ifdef SEG7_BRIGHTNESS_EN
    bright_d   = bright_q;
`endif
    if (wr) begin
      case (rsel)
        REG_CTRL: begin
          wr_val = wb_merge(32'(ctrl_q), wbs_dat_i, wbs_sel_i);
          ctrl_d = wr_val[2:0];
        end
        REG_DIGITS: begin
          wr_val   = wb_merge(32'(digits_q), wbs_dat_i, wbs_sel_i);
          digits_d = wr_val[DW-1:0];
        end
        REG_DP: begin
          wr_val = wb_merge(32'(dp_q), wbs_dat_i, wbs_sel_i);
          dp_d   = wr_val[NUM_DIGITS-1:0];
        end
        REG_SCAN_DIV: begin
          wr_val     = wb_merge(32'(scan_div_q), wbs_dat_i, wbs_sel_i);
          scan_div_d = wr_val[SCAN_DIV_W-1:0];
          div_wr     = 1'b1;
        end
`ifdef SEG7_BRIGHTNESS_EN
        REG_BRIGHT: begin
          wr_val   = wb_merge(32'(bright_q), wbs_dat_i, wbs_sel_i);
          bright_d = wr_val[3:0];
        end
`endif
        default: ;
      endcase
    end
  end

  // Read mux and single-cycle ack; data is zero outside the ack cycle
  always_comb begin
    rd_data = '0;
    case (rsel)
      REG_CTRL:     rd_data[2:0]            = ctrl_q;
      REG_DIGITS:   rd_data[DW-1:0]         = digits_q;
      REG_DP:       rd_data[NUM_DIGITS-1:0] = dp_q;
      REG_SCAN_DIV: rd_data[SCAN_DIV_W-1:0] = scan_div_q;
`ifdef SEG7_BRIGHTNESS_EN
      REG_BRIGHT:   rd_data[3:0]            = bright_q;
`endif
      default: ;
    endcase
    ack_d = req;
    dat_d = (req & ~wbs_we_i) ? rd_data : '0;
  end

  // Scan divider and digit index; held at zero while disabled
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    idx_d      = idx_q;
    if (!en) begin
      scan_cnt_d = '0;
      idx_d      = '0;
    end else if (div_wr) begin
      scan_cnt_d = '0;
    end else if (scan_cnt_q == scan_div_q) begin
      scan_cnt_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end
  end

`ifdef SEG7_BRIGHTNESS_EN
  // Free-running PWM phase; digits lit only while phase <= BRIGHT
  always_comb begin
    pwm_d  = pwm_q + 4'd1;
    pwm_on = (pwm_q <= bright_q);
  end
`else
  assign pwm_on = 1'b1;
`endif

  assign nib = digits_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble (nib),
    .seg    (hex_seg)
  );

  // Next pad values: gate by enable, then apply common-anode inversion
  always_comb begin
    seg_d = en ? hex_seg : '0;
    dpo_d = en & dp_q[idx_q];
    dig_d = (en & pwm_on) ? (NUM_DIGITS'(1) << idx_q) : '0;
    if (inv) begin
      seg_d = ~seg_d;
      dpo_d = ~dpo_d;
      dig_d = ~dig_d;
    end
    oeb_d = {OW{~ctrl_q[CTRL_OE]}};
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      digits_q   <= '0;
      dp_q       <= '0;
      scan_div_q <= SCAN_DIV_W'(SCAN_DIV_RST);
      ack_q      <= 1'b0;
      dat_q      <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= '0;
      dpo_q      <= 1'b0;
      dig_q      <= '0;
      oeb_q      <= '1;
`ifdef SEG7_BRIGHTNESS_EN
      bright_q   <= BRIGHT_RST;
      pwm_q      <= '0;
`endif
    end else begin
      ctrl_q     <= ctrl_d;
      digits_q   <= digits_d;
      dp_q       <= dp_d;
      scan_div_q <= scan_div_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dpo_q      <= dpo_d;
      dig_q      <= dig_d;
      oeb_q      <= oeb_d;
`ifdef SEG7_BRIGHTNESS_EN
      bright_q   <= bright_d;
      pwm_q      <= pwm_d;
`endif
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign seg_out   = seg_q;
  assign dp_out    = dpo_q;
  assign dig_en    = dig_q;
  assign io_oeb    = oeb_q;

  // Byte-address bits and unselected write-data bits are don't-care
  assign unused_ok = ^{wbs_adr_i[1:0], wr_val};

endmodule
